// File: rtl/nanci_sort_sched.sv
// Shearsort sequencer for the Nanci PE mesh: steps alternating row/column
// odd-even-transposition phases and broadcasts axis, parity and latch strobe.
module nanci_sort_sched #(
  parameter int SQRT_N      = 4,
  parameter int LOG_SQRT_N  = 2,
  parameter int SORT_CYCLES = 1,
  parameter int PHASE_W     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_hold,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_axis,
  output logic               o_parity,
  output logic               o_latch,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_final
);

  localparam int NUM_PHASES = 2 * LOG_SQRT_N + 1;
  localparam int HOLD_W     = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;
  localparam int STEP_W     = (LOG_SQRT_N > 0) ? LOG_SQRT_N : 1;

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(SORT_CYCLES - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(SQRT_N - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(NUM_PHASES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic [PHASE_W-1:0]  phase_cnt;

  logic advance;
  logic step_end;
  logic phase_end;
  logic sort_end;

  assign advance   = (state == RUN) && !i_hold;
  assign step_end  = (hold_cnt == HOLD_LAST);
  assign phase_end = (step_cnt == STEP_LAST);
  assign sort_end  = advance && step_end && phase_end && (phase_cnt == PHASE_LAST);

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of its peers, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment up front keeps every path assigned, so no
  // latch is inferred for state_nxt.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (sort_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters sit at zero outside RUN, so entering RUN starts a clean schedule
  // and DONE reports a zero phase without extra gating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt  <= '0;
      step_cnt  <= '0;
      phase_cnt <= '0;
    end else if (state != RUN) begin
      hold_cnt  <= '0;
      step_cnt  <= '0;
      phase_cnt <= '0;
    end else if (advance) begin
      if (!step_end) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end else begin
        hold_cnt <= '0;
        if (phase_end) begin
          step_cnt  <= '0;
          phase_cnt <= (phase_cnt == PHASE_LAST) ? '0 : phase_cnt + PHASE_W'(1);
        end else begin
          step_cnt <= step_cnt + STEP_W'(1);
        end
      end
    end
  end

  // Outputs decode flops only; o_latch alone also sees i_hold.
  always_comb begin
    o_busy   = (state == RUN);
    o_done   = (state == DONE);
    o_axis   = (state == RUN) && phase_cnt[0];
    o_parity = (state == RUN) && step_cnt[0];
    o_phase  = (state == RUN) ? phase_cnt : '0;
    o_final  = (state == RUN) && (phase_cnt == PHASE_LAST);
    o_latch  = advance && step_end;
  end

endmodule
